// File: rtl/alu_entry_sequencer_pkg.sv
// rtl/alu_entry_sequencer_pkg.sv - shared types and constants for the ALU entry sequencer
package alu_seq_pkg;

  localparam int WIDTH_DEF = 7;
  localparam int OPW_DEF   = 2;
  localparam int FLAGW_DEF = 5;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

  // One-hot front-panel LED patterns; CALC shows all LEDs dark
  localparam logic [3:0] LED_WAIT_A  = 4'b0001;
  localparam logic [3:0] LED_WAIT_B  = 4'b0010;
  localparam logic [3:0] LED_WAIT_OP = 4'b0100;
  localparam logic [3:0] LED_SHOW    = 4'b1000;
  localparam logic [3:0] LED_CALC    = 4'b0000;

endpackage

// File: rtl/alu_entry_sequencer_if.sv
// rtl/alu_entry_sequencer_if.sv - switch/button, ALU and display signals of the entry sequencer
interface alu_entry_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int FLAGW = FLAGW_DEF
) ();

  logic             enter_btn;
  logic             undo_btn;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic [FLAGW-1:0] alu_flags;
  logic [WIDTH-1:0] result_q;
  logic [FLAGW-1:0] flags_q;
  logic             result_valid;
  logic [WIDTH-1:0] display_value;
  logic [3:0]       state_leds;

  // Sequencer side
  modport slave (
    input  enter_btn, undo_btn, data_in, alu_result, alu_flags,
    output alu_a, alu_b, alu_op, result_q, flags_q, result_valid,
           display_value, state_leds
  );

  // Board / ALU side
  modport master (
    output enter_btn, undo_btn, data_in, alu_result, alu_flags,
    input  alu_a, alu_b, alu_op, result_q, flags_q, result_valid,
           display_value, state_leds
  );

endinterface

// File: rtl/alu_entry_sequencer_rise_pulse.sv
// rtl/alu_entry_sequencer_rise_pulse.sv - rising-edge detector for an already-synchronised button level
module rise_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  // Previous level; resets high so a button held through reset does not fire
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= level_i;
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/alu_entry_sequencer.sv
// rtl/alu_entry_sequencer.sv - steps A, B and opcode entry, then captures the ALU result for display
module alu_entry_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int FLAGW = FLAGW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_entry_sequencer_if.slave  bus
);

  seq_state_t       state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] result_q;
  logic [FLAGW-1:0] flags_q;
  logic             result_valid_q;
  logic             enter_pulse;
  logic             undo_pulse;
  logic [WIDTH-1:0] display_d;
  logic [3:0]       leds_d;

  rise_pulse u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.enter_btn),
    .pulse_o (enter_pulse)
  );

  rise_pulse u_undo_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.undo_btn),
    .pulse_o (undo_pulse)
  );

  // Entry FSM; undo takes precedence over enter, and CALC ignores both
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT_A;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (!undo_pulse && enter_pulse) begin
            alu_a_q <= bus.data_in;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (undo_pulse) begin
            state_q <= WAIT_A;
          end else if (enter_pulse) begin
            alu_b_q <= bus.data_in;
            state_q <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (undo_pulse) begin
            state_q <= WAIT_B;
          end else if (enter_pulse) begin
            alu_op_q <= bus.data_in[OPW-1:0];
            state_q  <= CALC;
          end
        end
        CALC: begin
          result_q       <= bus.alu_result;
          flags_q        <= bus.alu_flags;
          result_valid_q <= 1'b1;
          state_q        <= SHOW;
        end
        SHOW: begin
          if (undo_pulse) begin
            result_valid_q <= 1'b0;
            state_q        <= WAIT_OP;
          end else if (enter_pulse) begin
            result_valid_q <= 1'b0;
            state_q        <= WAIT_A;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          state_q        <= WAIT_A;
        end
      endcase
    end
  end

  // Display source and LED pattern follow the current state
  always_comb begin
    display_d = '0;
    leds_d    = LED_CALC;
    case (state_q)
      WAIT_A: begin
        display_d = bus.data_in;
        leds_d    = LED_WAIT_A;
      end
      WAIT_B: begin
        display_d = bus.data_in;
        leds_d    = LED_WAIT_B;
      end
      WAIT_OP: begin
        display_d = {{(WIDTH-OPW){1'b0}}, bus.data_in[OPW-1:0]};
        leds_d    = LED_WAIT_OP;
      end
      CALC: begin
        display_d = {{(WIDTH-OPW){1'b0}}, alu_op_q};
        leds_d    = LED_CALC;
      end
      SHOW: begin
        display_d = result_q;
        leds_d    = LED_SHOW;
      end
      default: begin
        display_d = '0;
        leds_d    = LED_CALC;
      end
    endcase
  end

  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.result_q      = result_q;
  assign bus.flags_q       = flags_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.display_value = display_d;
  assign bus.state_leds    = leds_d;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// tb/tb_alu_entry_sequencer.sv - directed checks of the ALU entry sequencer
module tb_alu_entry_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  alu_entry_sequencer_if bus ();

  alu_entry_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ALU stub: sum of operands, no flags
  assign bus.alu_result = bus.alu_a + bus.alu_b;
  assign bus.alu_flags  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input int val);
    bus.data_in   = 7'(val);
    bus.enter_btn = 1'b1;
    tick();
    bus.enter_btn = 1'b0;
    tick();
  endtask

  task automatic press_undo();
    bus.undo_btn = 1'b1;
    tick();
    bus.undo_btn = 1'b0;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    reset         = 1'b1;
    bus.enter_btn = 1'b1;
    bus.undo_btn  = 1'b0;
    bus.data_in   = '0;

    // Reset with enter held; release must not produce a pulse
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_leds", bus.state_leds, 4'b0001);
    chk("rst_a", bus.alu_a, 0);
    chk("rst_b", bus.alu_b, 0);
    chk("rst_op", bus.alu_op, 0);
    chk("rst_res", bus.result_q, 0);
    chk("rst_flags", bus.flags_q, 0);
    chk("rst_valid", bus.result_valid, 0);
    bus.enter_btn = 1'b0;
    tick();
    chk("rst_still_a", bus.state_leds, 4'b0001);

    // 25 + 10, opcode 0
    press_enter(25);
    chk("a25", bus.alu_a, 25);
    chk("leds_b", bus.state_leds, 4'b0010);
    bus.data_in = 7'd99;
    #1;
    chk("disp_live_b", bus.display_value, 99);
    press_enter(10);
    chk("b10", bus.alu_b, 10);
    chk("leds_op", bus.state_leds, 4'b0100);
    bus.data_in = 7'd6;
    #1;
    chk("disp_op_trunc", bus.display_value, 2);
    bus.data_in   = 7'd0;
    bus.enter_btn = 1'b1;
    tick();
    chk("calc_leds", bus.state_leds, 4'b0000);
    chk("calc_op", bus.alu_op, 0);
    chk("calc_valid", bus.result_valid, 0);
    bus.enter_btn = 1'b0;
    tick();
    chk("show_res", bus.result_q, 35);
    chk("show_valid", bus.result_valid, 1);
    chk("show_disp", bus.display_value, 35);
    chk("show_leds", bus.state_leds, 4'b1000);

    // Undo from SHOW, then re-enter opcode 1
    press_undo();
    chk("undo_show_leds", bus.state_leds, 4'b0100);
    chk("undo_show_valid", bus.result_valid, 0);
    chk("undo_show_res", bus.result_q, 35);
    bus.data_in   = 7'd1;
    bus.enter_btn = 1'b1;
    tick();
    chk("recalc_leds", bus.state_leds, 4'b0000);
    chk("recalc_disp", bus.display_value, 1);
    bus.enter_btn = 1'b0;
    tick();
    chk("reshow_leds", bus.state_leds, 4'b1000);
    chk("reshow_res", bus.result_q, 35);
    chk("reshow_op", bus.alu_op, 1);

    // SHOW -> WAIT_A keeps registers
    press_enter(3);
    chk("show_exit_leds", bus.state_leds, 4'b0001);
    chk("show_exit_valid", bus.result_valid, 0);
    chk("show_exit_a", bus.alu_a, 25);
    chk("show_exit_res", bus.result_q, 35);

    // A=5, B=3, undo in WAIT_OP, new B=9, opcode 0 -> 14; undo during CALC dropped
    press_enter(5);
    press_enter(3);
    press_undo();
    chk("undo_op_leds", bus.state_leds, 4'b0010);
    press_enter(9);
    chk("undo_op_back", bus.state_leds, 4'b0100);
    chk("undo_op_b", bus.alu_b, 9);
    chk("undo_op_a", bus.alu_a, 5);
    bus.data_in   = 7'd0;
    bus.enter_btn = 1'b1;
    tick();
    bus.enter_btn = 1'b0;
    bus.undo_btn  = 1'b1;
    tick();
    chk("calc_drop_leds", bus.state_leds, 4'b1000);
    chk("calc_res14", bus.result_q, 14);
    bus.undo_btn = 1'b0;
    tick();
    chk("calc_drop_hold", bus.state_leds, 4'b1000);

    // Simultaneous enter and undo in WAIT_B: undo wins
    press_enter(0);
    press_enter(7);
    chk("both_pre_leds", bus.state_leds, 4'b0010);
    bus.data_in   = 7'd100;
    bus.enter_btn = 1'b1;
    bus.undo_btn  = 1'b1;
    tick();
    chk("both_leds", bus.state_leds, 4'b0001);
    chk("both_b", bus.alu_b, 9);
    bus.enter_btn = 1'b0;
    bus.undo_btn  = 1'b0;
    tick();

    // Undo in WAIT_A does nothing
    press_undo();
    chk("undo_a_leds", bus.state_leds, 4'b0001);

    // Enter held 50 cycles advances once
    bus.data_in   = 7'd4;
    bus.enter_btn = 1'b1;
    repeat (50) tick();
    chk("held_leds", bus.state_leds, 4'b0010);
    chk("held_a", bus.alu_a, 4);
    bus.enter_btn = 1'b0;
    tick();

    // Reset mid-sequence wins over a simultaneous enter
    press_enter(8);
    chk("pre_rst_leds", bus.state_leds, 4'b0100);
    reset         = 1'b1;
    bus.enter_btn = 1'b1;
    tick();
    chk("mid_rst_leds", bus.state_leds, 4'b0001);
    chk("mid_rst_a", bus.alu_a, 0);
    chk("mid_rst_b", bus.alu_b, 0);
    chk("mid_rst_op", bus.alu_op, 0);
    chk("mid_rst_res", bus.result_q, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_leds", bus.state_leds, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
